// File: rtl/cache_arb_pkg.sv
// Shared types for the instruction/data cache memory-port arbiter.
package cache_arb_pkg;

  localparam int LINE_W = 256;

  typedef enum logic [2:0] {
    IDLE,
    I_ADDR,
    I_DATA,
    D_ADDR,
    D_DATA
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INST,
    OWN_DATA
  } owner_t;

  // Which requester owns the memory port in a given state.
  function automatic owner_t state_owner(arb_state_t s);
    case (s)
      I_ADDR, I_DATA: state_owner = OWN_INST;
      D_ADDR, D_DATA: state_owner = OWN_DATA;
      default:        state_owner = OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cache_arb_select.sv
// Grant decision taken in IDLE: data side wins unless the instruction side
// has been passed over STARVE_LIMIT times in a row.
module cache_arb_select #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             data_req,
  input  logic             inst_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant_inst,
  output logic             grant_data
);

  logic force_inst;

  // Fixed data priority with the starvation override.
  always_comb begin
    force_inst = inst_req & (starve_cnt == CNT_W'(STARVE_LIMIT));
    grant_data = data_req & ~force_inst;
    grant_inst = inst_req & ~grant_data;
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one sram-like memory port between the instruction and data caches,
// one transaction at a time, with a starvation guard for instruction fetch.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [31:0]       inst_addr,
  output logic [LINE_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  output logic [LINE_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok
);

  arb_state_t       state, state_next;
  owner_t           owner;
  logic             in_addr;
  logic [CNT_W-1:0] starve_cnt;
  logic             grant_inst, grant_data;

  // The instruction side is always issued as a read, so its write flag is dropped.
  logic unused_inst_wr;
  assign unused_inst_wr = inst_wr;

  cache_arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_select (
    .data_req  (data_req),
    .inst_req  (inst_req),
    .starve_cnt(starve_cnt),
    .grant_inst(grant_inst),
    .grant_data(grant_data)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Count data grants that passed over a waiting instruction request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_inst) begin
        starve_cnt <= '0;
      end else if (grant_data) begin
        if (!inst_req)                                starve_cnt <= '0;
        else if (starve_cnt != CNT_W'(STARVE_LIMIT))  starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state: grant from IDLE, advance on the downstream handshakes.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_data)      state_next = D_ADDR;
        else if (grant_inst) state_next = I_ADDR;
      end
      I_ADDR: begin
        if (mem_addr_ok) state_next = mem_data_ok ? IDLE : I_DATA;
      end
      D_ADDR: begin
        if (mem_addr_ok) state_next = mem_data_ok ? IDLE : D_DATA;
      end
      I_DATA, D_DATA: begin
        if (mem_data_ok) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: route the owner's payload down and the memory handshake back up.
  always_comb begin
    owner        = state_owner(state);
    in_addr      = (state == I_ADDR) || (state == D_ADDR);
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = 2'd0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    inst_rdata   = '0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    case (owner)
      OWN_INST: begin
        inst_rdata = mem_rdata;
        if (in_addr) begin
          mem_req      = 1'b1;
          mem_size     = inst_size;
          mem_addr     = inst_addr;
          inst_addr_ok = mem_addr_ok;
          inst_data_ok = mem_addr_ok & mem_data_ok;
        end else begin
          inst_data_ok = mem_data_ok;
        end
      end
      OWN_DATA: begin
        data_rdata = mem_rdata;
        if (in_addr) begin
          mem_req      = 1'b1;
          mem_wr       = data_wr;
          mem_size     = data_size;
          mem_addr     = data_addr;
          mem_wdata    = data_wdata;
          data_addr_ok = mem_addr_ok;
          data_data_ok = mem_addr_ok & mem_data_ok;
        end else begin
          data_data_ok = mem_data_ok;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a per-cycle vector table for the
// basic flows plus hand sequences for starvation and mid-transaction reset.
module tb_cache_mem_arbiter;
  import cache_arb_pkg::*;

  localparam logic [31:0]  IADDR = 32'hBFC0_0020;
  localparam logic [31:0]  DADDR = 32'h8000_1004;
  localparam logic [31:0]  WDATA = 32'hDEAD_BEEF;
  localparam logic [1:0]   ISIZE = 2'd3;
  localparam logic [1:0]   DSIZE = 2'd2;
  localparam logic [255:0] PAT   =
    256'h0123456789ABCDEF_FEDCBA9876543210_A5A5A5A55A5A5A5A_1122334455667788;

  logic              clk = 1'b0;
  logic              resetn;
  logic              inst_req, inst_wr;
  logic [1:0]        inst_size;
  logic [31:0]       inst_addr;
  logic [LINE_W-1:0] inst_rdata;
  logic              inst_addr_ok, inst_data_ok;
  logic              data_req, data_wr;
  logic [1:0]        data_size;
  logic [31:0]       data_addr, data_wdata;
  logic [LINE_W-1:0] data_rdata;
  logic              data_addr_ok, data_data_ok;
  logic              mem_req, mem_wr;
  logic [1:0]        mem_size;
  logic [31:0]       mem_addr, mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_addr_ok, mem_data_ok;

  int n_cmp  = 0;
  int n_fail = 0;

  cache_mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus and the outputs expected in that same cycle.
  // own: which side's payload should appear on mem_* (0 none, 1 inst, 2 data).
  typedef struct {
    bit       ireq, dreq, aok, dok;
    bit [1:0] own;
    bit       iaok, idok, daok, ddok;
    bit       ird, drd;
  } vec_t;

  function automatic vec_t mk(bit ireq, bit dreq, bit aok, bit dok, bit [1:0] own,
                              bit iaok, bit idok, bit daok, bit ddok, bit ird, bit drd);
    vec_t v;
    v.ireq = ireq; v.dreq = dreq; v.aok = aok; v.dok = dok; v.own = own;
    v.iaok = iaok; v.idok = idok; v.daok = daok; v.ddok = ddok;
    v.ird = ird; v.drd = drd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    @(negedge clk);
    inst_req    = v.ireq;
    data_req    = v.dreq;
    mem_addr_ok = v.aok;
    mem_data_ok = v.dok;
    #1;
    checkOutput($sformatf("r%0d mem_req", idx), mem_req, v.own != 2'd0);
    checkOutput($sformatf("r%0d mem_wr", idx), mem_wr, v.own == 2'd2);
    checkOutput($sformatf("r%0d mem_addr", idx), mem_addr,
                v.own == 2'd1 ? IADDR : (v.own == 2'd2 ? DADDR : 32'd0));
    checkOutput($sformatf("r%0d mem_size", idx), mem_size,
                v.own == 2'd1 ? ISIZE : (v.own == 2'd2 ? DSIZE : 2'd0));
    checkOutput($sformatf("r%0d mem_wdata", idx), mem_wdata, v.own == 2'd2 ? WDATA : 32'd0);
    checkOutput($sformatf("r%0d inst_addr_ok", idx), inst_addr_ok, v.iaok);
    checkOutput($sformatf("r%0d inst_data_ok", idx), inst_data_ok, v.idok);
    checkOutput($sformatf("r%0d data_addr_ok", idx), data_addr_ok, v.daok);
    checkOutput($sformatf("r%0d data_data_ok", idx), data_data_ok, v.ddok);
    checkOutput($sformatf("r%0d inst_rdata", idx), inst_rdata, v.ird ? PAT : 256'd0);
    checkOutput($sformatf("r%0d data_rdata", idx), data_rdata, v.drd ? PAT : 256'd0);
  endtask

  vec_t vecs[18];

  initial begin
    int   dcount, maxcnt, cnt_at_grant, dcount_at;
    bit   igrant, got_a, got_d;
    logic [255:0] rd;

    // Inst-only read, simultaneous requests, then same-cycle handshake.
    vecs[0]  = mk(1,0,1,0, 2'd0, 0,0,0,0, 0,0);
    vecs[1]  = mk(1,0,0,0, 2'd1, 0,0,0,0, 1,0);
    vecs[2]  = mk(1,0,1,0, 2'd1, 1,0,0,0, 1,0);
    vecs[3]  = mk(0,0,0,0, 2'd0, 0,0,0,0, 1,0);
    vecs[4]  = mk(0,0,0,0, 2'd0, 0,0,0,0, 1,0);
    vecs[5]  = mk(0,0,0,1, 2'd0, 0,1,0,0, 1,0);
    vecs[6]  = mk(0,0,1,0, 2'd0, 0,0,0,0, 0,0);
    vecs[7]  = mk(1,1,0,0, 2'd0, 0,0,0,0, 0,0);
    vecs[8]  = mk(1,1,1,0, 2'd2, 0,0,1,0, 0,1);
    vecs[9]  = mk(1,0,0,0, 2'd0, 0,0,0,0, 0,1);
    vecs[10] = mk(1,0,0,1, 2'd0, 0,0,0,1, 0,1);
    vecs[11] = mk(1,0,0,0, 2'd0, 0,0,0,0, 0,0);
    vecs[12] = mk(1,0,1,0, 2'd1, 1,0,0,0, 1,0);
    vecs[13] = mk(0,0,0,1, 2'd0, 0,1,0,0, 1,0);
    vecs[14] = mk(0,0,0,0, 2'd0, 0,0,0,0, 0,0);
    vecs[15] = mk(0,1,0,0, 2'd0, 0,0,0,0, 0,0);
    vecs[16] = mk(0,1,1,1, 2'd2, 0,0,1,1, 0,1);
    vecs[17] = mk(0,0,0,0, 2'd0, 0,0,0,0, 0,0);

    inst_wr = 1'b1; inst_size = ISIZE; inst_addr = IADDR;
    data_wr = 1'b1; data_size = DSIZE; data_addr = DADDR; data_wdata = WDATA;
    mem_rdata = PAT;

    // Reset with requests and handshakes active: everything must stay quiet.
    resetn = 1'b0; inst_req = 1'b1; data_req = 1'b1;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst mem_req", mem_req, 1'b0);
    checkOutput("rst mem_addr", mem_addr, 32'd0);
    checkOutput("rst mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 4'd0);
    checkOutput("rst state", dut.state, IDLE);
    checkOutput("rst starve_cnt", dut.starve_cnt, 3'd0);
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 18; i++) applyStimulus(i, vecs[i]);
    checkOutput("same_cycle idle", dut.state, IDLE);

    // Starvation guard: both sides requesting, bridge completes in one cycle.
    @(negedge clk);
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    dcount = 0; maxcnt = 0; cnt_at_grant = -1; dcount_at = -1; igrant = 1'b0;
    for (int c = 0; c < 40 && !igrant; c++) begin
      @(negedge clk); #1;
      if (int'(dut.starve_cnt) > maxcnt) maxcnt = int'(dut.starve_cnt);
      if (data_data_ok) dcount++;
      if (inst_addr_ok) begin
        igrant = 1'b1;
        dcount_at = dcount;
        cnt_at_grant = int'(dut.starve_cnt);
      end
    end
    checkOutput("starve inst granted", igrant, 1'b1);
    checkOutput("starve data before inst", dcount_at, 4);
    checkOutput("starve peak cnt", maxcnt, 4);
    checkOutput("starve cnt cleared", cnt_at_grant, 0);
    @(negedge clk);
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;

    // Reset while the instruction side is waiting for its line.
    @(negedge clk); inst_req = 1'b1;
    @(negedge clk); mem_addr_ok = 1'b1;
    @(negedge clk); inst_req = 1'b0; mem_addr_ok = 1'b0;
    #1;
    checkOutput("midrst in I_DATA", dut.state, I_DATA);
    resetn = 1'b0;
    mem_data_ok = 1'b1;
    #1;
    checkOutput("midrst mem_req", mem_req, 1'b0);
    checkOutput("midrst inst_data_ok", inst_data_ok, 1'b0);
    checkOutput("midrst oks", {inst_addr_ok, data_addr_ok, data_data_ok}, 3'd0);
    checkOutput("midrst state", dut.state, IDLE);
    mem_data_ok = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Fresh instruction fetch after reset must complete.
    @(negedge clk);
    inst_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    got_a = 1'b0; got_d = 1'b0; rd = '0;
    for (int c = 0; c < 10 && !got_d; c++) begin
      @(negedge clk); #1;
      if (inst_addr_ok) got_a = 1'b1;
      if (inst_data_ok) begin
        got_d = 1'b1;
        rd = inst_rdata;
        inst_req = 1'b0;
      end
    end
    checkOutput("post-rst addr_ok", got_a, 1'b1);
    checkOutput("post-rst data_ok", got_d, 1'b1);
    checkOutput("post-rst rdata", rd, PAT);
    @(negedge clk);
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
